// File: rtl/act_pkg.sv
// act_pkg: shared definitions for the activation scheduler.
//   - operand/result width helper (feature extension + 16 bits)
//   - scheduler FSM state encoding
//   - datapath mode constants and the Q.6 fixed-point unit value
package act_pkg;

  localparam int FEATURE_WIDE_DEF = 4;
  localparam int FRAC_BITS        = 6;
  localparam int FX_ONE           = 64;   // 1.0 with 6 fractional bits

  localparam logic MODE_TANH = 1'b0;
  localparam logic MODE_SIGM = 1'b1;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_SWITCH = 2'd2
  } sched_state_e;

  function automatic int act_w(input int feature_wide);
    return feature_wide + 16;
  endfunction

endpackage

// File: rtl/act_res_fifo.sv
// act_res_fifo: show-ahead synchronous FIFO with occupancy count.
// Ports:
//   clk, rst_n   clock, async active-low reset (empties the FIFO)
//   i_wr/i_wdata write strobe and data (caller guarantees no overflow)
//   i_rd         read request, ignored while empty
//   o_rdata      head entry, forced to 0 while empty
//   o_empty      FIFO empty
//   o_count      number of stored entries (0..DEPTH)
module act_res_fifo #(
  parameter  int WIDTH = 22,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_rd,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_rd_en;

  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign w_rd_en = i_rd && !o_empty;
  // Head is masked so stale memory never shows after reset.
  assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (i_wr) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_wr)    r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_wr, w_rd_en})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/act_sched.sv
// act_sched: round-robin scheduler of NUM_REQ requesters onto a shared
// fixed-latency tanh/sigmoid datapath, with result tagging and a
// credit-protected result FIFO.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   req_valid/req_data/req_choice  per-requester operand, mode (1=sigmoid)
//   req_ready                   one-hot grant
//   act_in_data/act_choice/act_en/act_mac_en  datapath drive
//   act_out_data                datapath result, ACT_LAT cycles after issue
//   res_valid/res_ready/res_id/res_data  result stream
//
// state  | meaning
// RUN    | grant the round-robin winner when its mode matches and credit exists
// DRAIN  | mode mismatch seen; wait for every in-flight operand to return
// SWITCH | datapath empty; flip mode, then back to RUN to serve pending winner
module act_sched
  import act_pkg::*;
#(
  parameter  int FEATURE_WIDE = FEATURE_WIDE_DEF,
  parameter  int NUM_REQ      = 4,
  parameter  int ACT_LAT      = 4,
  parameter  int FIFO_DEPTH   = 8,
  localparam int W            = act_w(FEATURE_WIDE),
  localparam int IDW          = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*W-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_choice,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [W-1:0]         act_in_data,
  output logic                 act_choice,
  output logic                 act_en,
  output logic                 act_mac_en,
  input  logic [W-1:0]         act_out_data,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [IDW-1:0]       res_id,
  output logic [W-1:0]         res_data
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int LW = $clog2(ACT_LAT + 1);

  sched_state_e   r_state;
  sched_state_e   w_state_nxt;
  logic           r_mode;
  logic [IDW-1:0] r_rr_ptr;
  logic           r_pend_vld;
  logic [IDW-1:0] r_pend_id;
  logic [ACT_LAT-1:0] r_tag_vld;
  logic [IDW-1:0] r_tag_id [ACT_LAT];
  logic [LW-1:0]  r_inflight;

  logic           w_rr_found;
  logic [IDW-1:0] w_rr_id;
  int             w_idx;
  logic           w_pend_use;
  logic           w_sel_found;
  logic [IDW-1:0] w_sel_id;
  logic           w_credit;
  logic           w_issue;
  logic           w_capture;
  logic           w_pend_set;
  logic           w_mode_flip;
  logic [CW-1:0]  w_fifo_count;
  logic           w_fifo_empty;
  logic [IDW+W-1:0] w_fifo_rdata;

  // First valid requester at or after the round-robin pointer.
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_id    = '0;
    w_idx      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = (int'(r_rr_ptr) + k) % NUM_REQ;
      if (!w_rr_found && req_valid[w_idx]) begin
        w_rr_found = 1'b1;
        w_rr_id    = IDW'(w_idx);
      end
    end
  end

  // A winner that forced a mode switch keeps priority once RUN resumes,
  // so the minority mode cannot be starved.
  assign w_pend_use  = r_pend_vld && req_valid[r_pend_id];
  assign w_sel_found = w_pend_use || w_rr_found;
  assign w_sel_id    = w_pend_use ? r_pend_id : w_rr_id;

  assign w_credit  = (int'(w_fifo_count) + int'(r_inflight)) < FIFO_DEPTH;
  assign w_capture = r_tag_vld[ACT_LAT-1];

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_pend_set  = 1'b0;
    w_mode_flip = 1'b0;
    unique case (r_state)
      ST_RUN: begin
        if (w_sel_found) begin
          if (req_choice[w_sel_id] != r_mode) begin
            w_pend_set  = 1'b1;
            w_state_nxt = ST_DRAIN;
          end else if (w_credit) begin
            w_issue = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (r_inflight == '0) w_state_nxt = ST_SWITCH;
      end
      ST_SWITCH: begin
        w_mode_flip = 1'b1;
        w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (w_issue) req_ready[w_sel_id] = 1'b1;
  end

  assign act_in_data = w_issue ? req_data[w_sel_id*W +: W] : '0;
  assign act_choice  = r_mode;
  assign act_en      = w_issue || (r_inflight != '0);
  assign act_mac_en  = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_RUN;
      r_mode     <= MODE_TANH;
      r_rr_ptr   <= '0;
      r_pend_vld <= 1'b0;
      r_pend_id  <= '0;
      r_tag_vld  <= '0;
      r_inflight <= '0;
      for (int k = 0; k < ACT_LAT; k++) r_tag_id[k] <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_mode_flip) r_mode <= ~r_mode;

      if (w_issue)
        r_rr_ptr <= (w_sel_id == IDW'(NUM_REQ-1)) ? '0 : w_sel_id + 1'b1;

      if (w_pend_set) begin
        r_pend_vld <= 1'b1;
        r_pend_id  <= w_sel_id;
      end else if (r_state == ST_RUN && r_pend_vld &&
                   (w_issue || !req_valid[r_pend_id])) begin
        r_pend_vld <= 1'b0;
      end

      r_tag_vld   <= {r_tag_vld[ACT_LAT-2:0], w_issue};
      r_tag_id[0] <= w_sel_id;
      for (int k = 1; k < ACT_LAT; k++) r_tag_id[k] <= r_tag_id[k-1];

      case ({w_issue, w_capture})
        2'b10:   r_inflight <= r_inflight + 1'b1;
        2'b01:   r_inflight <= r_inflight - 1'b1;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  act_res_fifo #(
    .WIDTH (IDW + W),
    .DEPTH (FIFO_DEPTH)
  ) u_res_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_wr    (w_capture),
    .i_wdata ({r_tag_id[ACT_LAT-1], act_out_data}),
    .i_rd    (res_ready),
    .o_rdata (w_fifo_rdata),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign res_valid         = !w_fifo_empty;
  assign {res_id, res_data} = w_fifo_rdata;

endmodule

// File: tb/tb_act_sched.sv
module tb_act_sched;
  import act_pkg::*;

  localparam int N   = 4;
  localparam int W   = act_w(4);
  localparam int IDW = 2;
  localparam logic [W-1:0] SIG_OFS = W'(1000);

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req_valid;
  logic [N*W-1:0]   req_data;
  logic [N-1:0]     req_choice;
  logic [N-1:0]     req_ready;
  logic [W-1:0]     act_in_data;
  logic             act_choice, act_en, act_mac_en;
  logic [W-1:0]     act_out_data;
  logic             res_valid, res_ready;
  logic [IDW-1:0]   res_id;
  logic [W-1:0]     res_data;

  act_sched dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_choice(req_choice),
    .req_ready(req_ready),
    .act_in_data(act_in_data), .act_choice(act_choice), .act_en(act_en),
    .act_mac_en(act_mac_en), .act_out_data(act_out_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_data(res_data)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Stub datapath: 4-cycle pipe, choice recorded at input and compared at output.
  logic [W-1:0] sd [4];
  logic         sc [4];
  logic         sv [4];
  assign act_out_data = sd[3];

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin sd[k] <= '0; sc[k] <= 1'b0; sv[k] <= 1'b0; end
    end else begin
      for (int k = 1; k < 4; k++) begin sd[k] <= sd[k-1]; sc[k] <= sc[k-1]; sv[k] <= sv[k-1]; end
      sd[0] <= act_in_data + (act_choice ? SIG_OFS : '0);
      sc[0] <= act_choice;
      sv[0] <= |(req_valid & req_ready);
    end
  end

  always @(negedge clk) begin
    if (rst_n && sv[3]) chk("stub_choice_stable", act_choice, sc[3]);
  end

  // Scoreboard: every handshake pushes its expected result; results pop in order.
  typedef struct packed {
    logic [IDW-1:0] id;
    logic [W-1:0]   data;
  } exp_t;
  exp_t         exp_q[$];
  exp_t         e;
  logic [N-1:0] hs;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      hs = req_valid & req_ready;
      if (req_ready != '0) begin
        chk("grant_onehot", $onehot(req_ready), 1);
        chk("grant_valid", |hs, 1);
        chk("credit", exp_q.size() < 8, 1);
        chk("act_en_issue", act_en, 1);
      end
      for (int i = 0; i < N; i++) begin
        if (hs[i]) begin
          chk("grant_mode", req_choice[i], act_choice);
          e.id   = IDW'(i);
          e.data = req_data[i*W +: W] + (req_choice[i] ? SIG_OFS : '0);
          exp_q.push_back(e);
        end
      end
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("res_id", res_id, e.id);
          chk("res_data", res_data, e.data);
        end
      end
    end
  end

  // Requester-side stimulus state.
  logic [N-1:0] rv, rc;
  logic [W-1:0] rd [N];

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      req_valid[i]        = rv[i];
      req_choice[i]       = rc[i];
      req_data[i*W +: W]  = rd[i];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_req_ready"},   req_ready, 0);
    chk({p, "_act_in"},      act_in_data, 0);
    chk({p, "_act_choice"},  act_choice, 0);
    chk({p, "_act_en"},      act_en, 0);
    chk({p, "_act_mac_en"},  act_mac_en, 0);
    chk({p, "_res_valid"},   res_valid, 0);
    chk({p, "_res_id"},      res_id, 0);
    chk({p, "_res_data"},    res_data, 0);
  endtask

  task automatic do_reset();
    rv = '0; apply();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || res_valid) && n < 200) begin tick(); n++; end
    chk("drain_timeout", n < 200, 1);
  endtask

  function automatic int oh2i(input logic [N-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int   n, g, last, first, lastc;
  int   gq[$], rq[$];
  logic granted, pref;
  logic [N-1:0] gv;

  initial begin
    rst_n = 1'b0; res_ready = 1'b1;
    rv = '0; rc = '0;
    for (int i = 0; i < N; i++) rd[i] = '0;
    apply();
    tick(); tick();
    chk_reset("rst");
    rst_n = 1'b1;
    tick();

    // Single request: grant at t, result visible at t+5.
    do_reset();
    rv[0] = 1'b1; rd[0] = W'(FX_ONE); rc[0] = MODE_TANH; apply(); #1;
    chk("single_grant", req_ready, 4'b0001);
    chk("single_in", act_in_data, FX_ONE);
    chk("single_en", act_en, 1);
    tick(); rv[0] = 1'b0; apply();
    n = 1;
    while (!res_valid && n < 12) begin tick(); n++; end
    chk("single_latency", n, 5);
    chk("single_id", res_id, 0);
    chk("single_data", res_data, FX_ONE);
    wait_drain();

    // Round-robin: all four valid for 8 cycles.
    do_reset();
    for (int i = 0; i < N; i++) begin rv[i] = 1'b1; rd[i] = W'(100 + i); rc[i] = MODE_TANH; end
    apply();
    gq.delete(); rq.delete(); first = -1; lastc = -1;
    for (int c = 0; c < 16; c++) begin
      if (c == 8) begin rv = '0; apply(); end
      #1;
      if (req_ready != '0) gq.push_back(oh2i(req_ready));
      if (res_valid) begin
        rq.push_back(int'(res_id));
        if (first < 0) first = c;
        lastc = c;
      end
      tick();
    end
    chk("rr_num_grants", gq.size(), 8);
    for (int k = 0; k < gq.size(); k++) chk("rr_grant_order", gq[k], k % 4);
    chk("rr_num_results", rq.size(), 8);
    for (int k = 0; k < rq.size(); k++) chk("rr_result_order", rq[k], k % 4);
    chk("rr_no_gap", lastc - first, 7);
    wait_drain();

    // Mode switch: tanh req0 then sigmoid req1 after drain + switch.
    do_reset();
    rv[0] = 1'b1; rd[0] = W'(10); rc[0] = MODE_TANH;
    rv[1] = 1'b1; rd[1] = W'(20); rc[1] = MODE_SIGM;
    apply(); #1;
    chk("ms_grant0", req_ready, 4'b0001);
    tick(); rv[0] = 1'b0; apply(); #1;
    n = 1;
    while (req_ready == '0 && n < 20) begin tick(); #1; n++; end
    chk("ms_switch_latency", n, 7);
    chk("ms_grant1", req_ready, 4'b0010);
    chk("ms_choice", act_choice, 1);
    tick(); rv[1] = 1'b0; apply();
    wait_drain();

    // Backpressure: exactly FIFO_DEPTH grants, last one with 4 in flight + 3 stored.
    do_reset();
    res_ready = 1'b0;
    rv[2] = 1'b1; rd[2] = W'($urandom_range(0, 5000)); rc[2] = MODE_TANH; apply();
    g = 0; last = -1;
    for (int c = 0; c < 20; c++) begin
      #1;
      granted = req_ready[2];
      if (granted) begin g++; last = c; end
      tick();
      if (granted) begin rd[2] = W'($urandom_range(0, 5000)); apply(); end
    end
    chk("bp_grants", g, 8);
    chk("bp_credit_edge", last, 7);
    chk("bp_stalled", req_ready, 0);
    chk("bp_holding", res_valid, 1);
    res_ready = 1'b1;
    g = 0;
    for (int c = 0; c < 30; c++) begin
      #1;
      granted = req_ready[2];
      if (granted) g++;
      tick();
      if (granted) begin rd[2] = W'($urandom_range(0, 5000)); apply(); end
    end
    chk("bp_resume", g >= 20, 1);
    rv = '0; apply();
    wait_drain();

    // Reset with three operands in flight.
    do_reset();
    rv[0] = 1'b1; rc[0] = MODE_TANH; rd[0] = W'($urandom_range(0, 5000)); apply();
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("rm_grant", req_ready, 4'b0001);
      tick();
      rd[0] = W'($urandom_range(0, 5000)); apply();
    end
    rv = '0; apply();
    rst_n = 1'b0;
    tick(); tick();
    chk_reset("rm");
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin tick(); chk("rm_stale", res_valid, 0); end
    rv[3] = 1'b1; rc[3] = MODE_SIGM; rd[3] = W'(-50); apply(); #1;
    n = 0;
    while (!req_ready[3] && n < 10) begin tick(); #1; n++; end
    chk("rm_new_grant", n, 3);
    tick(); rv[3] = 1'b0; apply();
    n = 0;
    while (!res_valid && n < 20) begin tick(); n++; end
    chk("rm_new_id", res_id, 3);
    chk("rm_new_data", res_data, 950);
    wait_drain();

    // Randomized traffic against the scoreboard.
    do_reset();
    pref = MODE_TANH;
    for (int c = 0; c < 1500; c++) begin
      if (c % 100 == 0) pref = ~pref;
      for (int i = 0; i < N; i++) begin
        if (!rv[i] && $urandom_range(0, 99) < 35) begin
          rv[i] = 1'b1;
          rd[i] = W'($urandom_range(0, 60000)) - W'(30000);
          rc[i] = ($urandom_range(0, 9) < 8) ? pref : ~pref;
        end
      end
      res_ready = ($urandom_range(0, 99) < 70);
      apply(); #1;
      gv = req_ready & req_valid;
      tick();
      for (int i = 0; i < N; i++) if (gv[i]) rv[i] = 1'b0;
    end
    rv = '0; apply();
    res_ready = 1'b1;
    wait_drain();
    chk("final_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
